// File: rtl/fpnew_result_buffer.sv
// fpnew_result_buffer
// Small valid/ready FIFO placed after an FPU operation-group block. It holds
// the arbitrated result, status flags, extension bit and tag until the
// writeback port accepts them. It also accumulates sticky IEEE exception
// flags from delivered results and reports occupancy and busy state.
//
// Optional feature: define FPNEW_RESULT_BUF_BYPASS_EN to let an entry that
// arrives at an empty buffer appear on the outputs in the same cycle. If
// downstream accepts it in that cycle, the entry is never written. Without
// the macro, the outputs come only from storage, with one cycle of minimum
// latency.
module fpnew_result_buffer #(
    parameter int unsigned Width    = 64,
    parameter int unsigned TagWidth = 8,
    parameter int unsigned Depth    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [Width-1:0]           in_result_i,
    input  logic [4:0]                 in_status_i,
    input  logic                       in_ext_bit_i,
    input  logic [TagWidth-1:0]        in_tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [Width-1:0]           out_result_o,
    output logic [4:0]                 out_status_o,
    output logic                       out_ext_bit_o,
    output logic [TagWidth-1:0]        out_tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [4:0]                 fflags_o,
    input  logic                       clr_fflags_i,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DEPTH_C = CntW'(Depth);

    typedef struct packed {
        logic [Width-1:0]    result;
        logic [4:0]          status;
        logic                ext_bit;
        logic [TagWidth-1:0] tag;
    } entry_t;

    // Entry storage is deliberately left without reset; the outputs are
    // qualified by out_valid_o.
    entry_t          mem_r [Depth];
    logic [PtrW-1:0] wptr_r;
    logic [PtrW-1:0] rptr_r;
    logic [CntW-1:0] count_r;
    logic [4:0]      fflags_r;

    entry_t          in_entry_s;
    entry_t          head_s;
    logic            empty_s;
    logic            full_s;
    logic            bypass_s;
    logic            pass_s;
    logic            out_valid_s;
    logic            push_s;
    logic            pop_s;
    logic            wr_en_s;
    logic            rd_en_s;
    logic [4:0]      fflags_next_s;

    // Pack the incoming fields into one storage word.
    always_comb begin
        in_entry_s.result  = in_result_i;
        in_entry_s.status  = in_status_i;
        in_entry_s.ext_bit = in_ext_bit_i;
        in_entry_s.tag     = in_tag_i;
    end

    // Full and empty are derived only from the occupancy count.
    always_comb begin
        empty_s = (count_r == {CntW{1'b0}});
        full_s  = (count_r == DEPTH_C);
    end

`ifdef FPNEW_RESULT_BUF_BYPASS_EN
    // When the buffer is empty, a valid input is presented directly on the outputs.
    always_comb begin
        if (empty_s && in_valid_i && !flush_i) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
    end

    // Select the head entry: the bypassed input or the stored entry at rptr.
    always_comb begin
        if (bypass_s) begin
            head_s = in_entry_s;
        end else begin
            head_s = mem_r[rptr_r];
        end
    end
`else
    // No bypass: the outputs always come from storage.
    always_comb begin
        bypass_s = 1'b0;
        head_s   = mem_r[rptr_r];
    end
`endif

    // Handshakes and the storage and count update enables.
    always_comb begin
        out_valid_s = !empty_s || bypass_s;
        push_s      = in_valid_i && !full_s;
        pop_s       = out_valid_s && out_ready_i;
        // A bypassed entry consumed in the same cycle never touches storage.
        pass_s      = bypass_s && out_ready_i;
        wr_en_s     = push_s && !flush_i && !pass_s;
        rd_en_s     = pop_s && !flush_i && !pass_s;
    end

    // Sticky flags: an optional clear, then OR in the status of a delivered entry.
    always_comb begin
        if (clr_fflags_i) begin
            fflags_next_s = 5'b00000;
        end else begin
            fflags_next_s = fflags_r;
        end
        if (pop_s && !flush_i) begin
            fflags_next_s = fflags_next_s | head_s.status;
        end else begin
            fflags_next_s = fflags_next_s;
        end
    end

    // Pointers and occupancy. Flush has priority over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r  <= {PtrW{1'b0}};
            rptr_r  <= {PtrW{1'b0}};
            count_r <= {CntW{1'b0}};
        end else if (flush_i) begin
            wptr_r  <= {PtrW{1'b0}};
            rptr_r  <= {PtrW{1'b0}};
            count_r <= {CntW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rptr_r <= rptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + {{(CntW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CntW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky exception flags. Flush does not clear them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_r <= 5'b00000;
        end else begin
            fflags_r <= fflags_next_s;
        end
    end

    // Entry storage write. This storage has no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wptr_r] <= in_entry_s;
        end
    end

    assign in_ready_o    = !full_s;
    assign out_valid_o   = out_valid_s;
    assign out_result_o  = head_s.result;
    assign out_status_o  = head_s.status;
    assign out_ext_bit_o = head_s.ext_bit;
    assign out_tag_o     = head_s.tag;
    assign fflags_o      = fflags_r;
    assign count_o       = count_r;
    assign busy_o        = !empty_s || in_valid_i;

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed testbench for fpnew_result_buffer with hand-computed expectations.
// Both builds are covered: with and without FPNEW_RESULT_BUF_BYPASS_EN.
module tb_fpnew_result_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] in_result_i;
    logic [4:0]  in_status_i;
    logic        in_ext_bit_i;
    logic [7:0]  in_tag_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic [63:0] out_result_o;
    logic [4:0]  out_status_o;
    logic        out_ext_bit_o;
    logic [7:0]  out_tag_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [4:0]  fflags_o;
    logic        clr_fflags_i;
    logic [1:0]  count_o;
    logic        busy_o;

    int checks_q = 0;
    int errors_q = 0;

    fpnew_result_buffer #(.Width(64), .TagWidth(8), .Depth(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_result_i(in_result_i), .in_status_i(in_status_i),
        .in_ext_bit_i(in_ext_bit_i), .in_tag_i(in_tag_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
        .out_result_o(out_result_o), .out_status_o(out_status_o),
        .out_ext_bit_o(out_ext_bit_o), .out_tag_o(out_tag_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .fflags_o(fflags_o), .clr_fflags_i(clr_fflags_i),
        .count_o(count_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_q++;
        if (obs !== exp) begin
            errors_q++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] tag, input logic [4:0] st);
        in_valid_i   = v;
        in_tag_i     = tag;
        in_status_i  = st;
        in_result_i  = {56'h0, tag};
        in_ext_bit_i = tag[0];
    endtask

    logic [7:0] exp_tag;

    initial begin
        rst_ni       = 1'b0;
        in_result_i  = 64'h0;
        in_status_i  = 5'b00000;
        in_ext_bit_i = 1'b0;
        in_tag_i     = 8'h00;
        in_valid_i   = 1'b0;
        flush_i      = 1'b0;
        out_ready_i  = 1'b0;
        clr_fflags_i = 1'b0;
        step();
        step();
        check_val("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_val("rst_in_ready",  64'(in_ready_o),  64'd1);
        check_val("rst_busy",      64'(busy_o),      64'd0);
        check_val("rst_count",     64'(count_o),     64'd0);
        check_val("rst_fflags",    64'(fflags_o),    64'd0);
        rst_ni = 1'b1;
        step();

        // Single push followed by delivery.
        drive(1'b1, 8'h11, 5'b00001);
        in_result_i = 64'h3FF0_0000_0000_0000;
        out_ready_i = 1'b1;
        #1;
        check_val("t1_busy", 64'(busy_o), 64'd1);
`ifdef FPNEW_RESULT_BUF_BYPASS_EN
        check_val("t1_byp_valid", 64'(out_valid_o), 64'd1);
        check_val("t1_byp_tag",   64'(out_tag_o),   64'h11);
        step();
        drive(1'b0, 8'h00, 5'b00000);
`else
        check_val("t1_lat_valid", 64'(out_valid_o), 64'd0);
        step();
        drive(1'b0, 8'h00, 5'b00000);
        #1;
        check_val("t1_valid",  64'(out_valid_o), 64'd1);
        check_val("t1_tag",    64'(out_tag_o),   64'h11);
        check_val("t1_result", out_result_o,     64'h3FF0_0000_0000_0000);
        check_val("t1_count1", 64'(count_o),     64'd1);
        step();
`endif
        check_val("t1_fflags", 64'(fflags_o), 64'd1);
        check_val("t1_count0", 64'(count_o),  64'd0);

        // Fill the buffer while downstream stalls, then drain it in order.
        out_ready_i = 1'b0;
        drive(1'b1, 8'h01, 5'b00000);
        step();
        drive(1'b1, 8'h02, 5'b00000);
        step();
        drive(1'b1, 8'h03, 5'b00000);
        #1;
        check_val("t2_count2",  64'(count_o),    64'd2);
        check_val("t2_inready", 64'(in_ready_o), 64'd0);
        step();
        check_val("t2_stall_count", 64'(count_o),   64'd2);
        check_val("t2_stall_head",  64'(out_tag_o), 64'h01);
        drive(1'b0, 8'h00, 5'b00000);
        out_ready_i = 1'b1;
        #1;
        check_val("t2_head01", 64'(out_tag_o), 64'h01);
        step();
        check_val("t2_inready_after", 64'(in_ready_o), 64'd1);
        check_val("t2_count1",        64'(count_o),    64'd1);
        check_val("t2_head02",        64'(out_tag_o),  64'h02);
        check_val("t2_ext02",         64'(out_ext_bit_o), 64'd0);
        step();
        check_val("t2_empty", 64'(count_o), 64'd0);

        // Simultaneous push and pop at occupancy 1, repeated across pointer wrap.
        out_ready_i = 1'b0;
        drive(1'b1, 8'h10, 5'b00000);
        step();
        for (int i = 0; i < 5; i++) begin
            exp_tag = 8'h20 + 8'(i);
            drive(1'b1, exp_tag, 5'b00000);
            out_ready_i = 1'b1;
            step();
            check_val("t3_count", 64'(count_o),   64'd1);
            check_val("t3_head",  64'(out_tag_o), 64'(exp_tag));
        end
        drive(1'b0, 8'h00, 5'b00000);
        step();
        check_val("t3_drained", 64'(count_o), 64'd0);
        out_ready_i = 1'b0;

        // A flush drops the buffered entries and leaves the sticky flags unchanged.
        clr_fflags_i = 1'b1;
        step();
        clr_fflags_i = 1'b0;
        check_val("t4_clr", 64'(fflags_o), 64'd0);
        drive(1'b1, 8'h41, 5'b10000);
        step();
        drive(1'b1, 8'h42, 5'b10000);
        step();
        drive(1'b0, 8'h00, 5'b00000);
        check_val("t4_full", 64'(count_o), 64'd2);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        step();
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        check_val("t4_count",   64'(count_o),     64'd0);
        check_val("t4_valid",   64'(out_valid_o), 64'd0);
        check_val("t4_fflags",  64'(fflags_o),    64'd0);
        check_val("t4_inready", 64'(in_ready_o),  64'd1);

        // Clear the flags and deliver an entry in the same cycle.
        drive(1'b1, 8'h51, 5'b00100);
        step();
        drive(1'b0, 8'h00, 5'b00000);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check_val("t5_fflags_set", 64'(fflags_o), 64'b00100);
        drive(1'b1, 8'h52, 5'b00010);
        step();
        drive(1'b0, 8'h00, 5'b00000);
        clr_fflags_i = 1'b1;
        out_ready_i  = 1'b1;
        step();
        clr_fflags_i = 1'b0;
        out_ready_i  = 1'b0;
        check_val("t5_fflags_clrpop", 64'(fflags_o), 64'b00010);
        check_val("t5_count",         64'(count_o),  64'd0);

        // Push into an empty buffer while downstream is ready.
        drive(1'b1, 8'hAA, 5'b00000);
        out_ready_i = 1'b1;
        #1;
`ifdef FPNEW_RESULT_BUF_BYPASS_EN
        check_val("t6_byp_valid", 64'(out_valid_o), 64'd1);
        check_val("t6_byp_tag",   64'(out_tag_o),   64'hAA);
        step();
        drive(1'b0, 8'h00, 5'b00000);
        check_val("t6_byp_count", 64'(count_o), 64'd0);
`else
        check_val("t6_valid_now", 64'(out_valid_o), 64'd0);
        step();
        drive(1'b0, 8'h00, 5'b00000);
        #1;
        check_val("t6_valid_next", 64'(out_valid_o), 64'd1);
        check_val("t6_tag_next",   64'(out_tag_o),   64'hAA);
        step();
`endif
        out_ready_i = 1'b0;

        // Asynchronous reset in the middle of operation.
        drive(1'b1, 8'h61, 5'b01000);
        step();
        drive(1'b0, 8'h00, 5'b00000);
        check_val("t7_pre_count", 64'(count_o), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_val("t7_valid",   64'(out_valid_o), 64'd0);
        check_val("t7_count",   64'(count_o),     64'd0);
        check_val("t7_inready", 64'(in_ready_o),  64'd1);
        check_val("t7_fflags",  64'(fflags_o),    64'd0);
        step();
        rst_ni = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors_q, checks_q);
        $finish;
    end

endmodule
